// File: rtl/openram_testchip_ctrl_pkg.sv
// Shared widths, packet layout and chip-select helper for the OpenRAM test-chip controller.
package openram_testchip_ctrl_pkg;

   localparam int TOTAL_SIZE = 112;
   localparam int ADDR_SIZE  = 16;
   localparam int DATA_SIZE  = 32;
   localparam int WMASK_SIZE = 4;
   localparam int MAX_CHIPS  = 16;
   localparam int SEL_SIZE   = $clog2(MAX_CHIPS);

   // Packet bit positions of the two data fields that SRAM capture overwrites
   localparam int DIN0_LSB = 60;
   localparam int DIN1_LSB = 6;

   typedef struct packed {
      logic [ADDR_SIZE-1:0]  addr;
      logic [DATA_SIZE-1:0]  din;
      logic                  csb;
      logic                  web;
      logic [WMASK_SIZE-1:0] wmask;
   } port_t;

   // MSB first: sel, port 0, port 1 (4 + 54 + 54 = 112 bits)
   typedef struct packed {
      logic [SEL_SIZE-1:0] sel;
      port_t               p0;
      port_t               p1;
   } pkt_t;

   function automatic logic [MAX_CHIPS-1:0] csb_decode(input logic [SEL_SIZE-1:0] sel,
                                                       input logic               en);
      logic [MAX_CHIPS-1:0] v;
      v = '1;
      if (en) v[sel] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/openram_testchip_ctrl_if.sv
// Shared SRAM port-0/port-1 bus plus per-macro read-data returns.
interface openram_testchip_ctrl_if;
   import openram_testchip_ctrl_pkg::*;

   logic [ADDR_SIZE-1:0]                  addr0;
   logic [ADDR_SIZE-1:0]                  addr1;
   logic [DATA_SIZE-1:0]                  din0;
   logic [DATA_SIZE-1:0]                  din1;
   logic                                  web0;
   logic                                  web1;
   logic [WMASK_SIZE-1:0]                 wmask0;
   logic [WMASK_SIZE-1:0]                 wmask1;
   logic [MAX_CHIPS-1:0]                  csb0;
   logic [MAX_CHIPS-1:0]                  csb1;
   logic [MAX_CHIPS-1:0][DATA_SIZE-1:0]   data0;
   logic [MAX_CHIPS-1:0][DATA_SIZE-1:0]   data1;

   modport master (
      output addr0, addr1, din0, din1, web0, web1, wmask0, wmask1, csb0, csb1,
      input  data0, data1
   );

   modport slave (
      input  addr0, addr1, din0, din1, web0, web1, wmask0, wmask1, csb0, csb1,
      output data0, data1
   );

endinterface

// File: rtl/openram_testchip_ctrl_data_mux.sv
// Dual 16:1 read-data selector; narrow or absent macros are padded by the caller.
module openram_testchip_ctrl_data_mux
   import openram_testchip_ctrl_pkg::*;
(
   input  logic [SEL_SIZE-1:0]                 i_sel,
   input  logic [MAX_CHIPS-1:0][DATA_SIZE-1:0] i_data0,
   input  logic [MAX_CHIPS-1:0][DATA_SIZE-1:0] i_data1,
   output logic [DATA_SIZE-1:0]                o_data0,
   output logic [DATA_SIZE-1:0]                o_data1
);

   assign o_data0 = i_data0[i_sel];
   assign o_data1 = i_data1[i_sel];

endmodule

// File: rtl/openram_testchip_ctrl.sv
// Packet register with serial/parallel load and read-data capture; drives the
// shared SRAM buses and one-hot active-low chip selects from the packet.
module openram_testchip_ctrl
   import openram_testchip_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  la_in_load,
   input  logic [TOTAL_SIZE-1:0] la_data_in,
   input  logic                  la_sram_load,
   input  logic                  gpio_in,
   input  logic                  gpio_scan,
   input  logic                  gpio_sram_load,
   input  logic                  global_csb,
   openram_testchip_ctrl_if.master sram,
   output logic [TOTAL_SIZE-1:0] la_data_out,
   output logic                  gpio_out
);

   logic [TOTAL_SIZE-1:0] r_pkt;
   pkt_t                  w_pkt;
   logic [DATA_SIZE-1:0]  w_rd0;
   logic [DATA_SIZE-1:0]  w_rd1;
   logic                  w_en;

   assign w_pkt = r_pkt;

   openram_testchip_ctrl_data_mux u_data_mux (
      .i_sel   (w_pkt.sel),
      .i_data0 (sram.data0),
      .i_data1 (sram.data1),
      .o_data0 (w_rd0),
      .o_data1 (w_rd1)
   );

   // Parallel load beats shift, shift beats capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pkt <= '0;
      end else if (la_in_load) begin
         r_pkt <= la_data_in;
      end else if (gpio_scan) begin
         r_pkt <= {r_pkt[TOTAL_SIZE-2:0], gpio_in};
      end else if (la_sram_load || gpio_sram_load) begin
         r_pkt[DIN0_LSB +: DATA_SIZE] <= w_rd0;
         r_pkt[DIN1_LSB +: DATA_SIZE] <= w_rd1;
      end
   end

   assign w_en = !reset && !global_csb;

   assign sram.csb0   = csb_decode(w_pkt.sel, w_en && !w_pkt.p0.csb);
   assign sram.csb1   = csb_decode(w_pkt.sel, w_en && !w_pkt.p1.csb);
   assign sram.addr0  = w_pkt.p0.addr;
   assign sram.din0   = w_pkt.p0.din;
   assign sram.web0   = w_pkt.p0.web;
   assign sram.wmask0 = w_pkt.p0.wmask;
   assign sram.addr1  = w_pkt.p1.addr;
   assign sram.din1   = w_pkt.p1.din;
   assign sram.web1   = w_pkt.p1.web;
   assign sram.wmask1 = w_pkt.p1.wmask;

   assign la_data_out = r_pkt;
   assign gpio_out    = r_pkt[TOTAL_SIZE-1];

endmodule

// File: tb/tb_openram_testchip_ctrl.sv
// Scoreboard bench for openram_testchip_ctrl with behavioural SRAM macros on selects 0, 1 and 8.
module tb_openram_testchip_ctrl;
   import openram_testchip_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         reset, la_in_load, la_sram_load, gpio_in, gpio_scan, gpio_sram_load, global_csb;
   logic [111:0] la_data_in, la_data_out;
   logic         gpio_out;

   always #5 clk = ~clk;

   openram_testchip_ctrl_if bus ();

   openram_testchip_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .la_in_load     (la_in_load),
      .la_data_in     (la_data_in),
      .la_sram_load   (la_sram_load),
      .gpio_in        (gpio_in),
      .gpio_scan      (gpio_scan),
      .gpio_sram_load (gpio_sram_load),
      .global_csb     (global_csb),
      .sram           (bus),
      .la_data_out    (la_data_out),
      .gpio_out       (gpio_out)
   );

   // macro 0: 8x1024 dual-port, macro 1: 32x256 dual-port, macro 8: 32x256 single-port
   logic [7:0]  mem0 [1024];
   logic [31:0] mem1 [256];
   logic [31:0] mem8 [256];
   logic [7:0]  m0_d0 = '0, m0_d1 = '0;
   logic [31:0] m1_d0 = '0, m1_d1 = '0, m8_d0 = '0;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] mask);
      logic [31:0] v;
      v = old_w;
      for (int b = 0; b < 4; b++) if (mask[b]) v[8*b +: 8] = new_w[8*b +: 8];
      return v;
   endfunction

   always @(posedge clk) begin
      if (!bus.csb0[0]) begin
         if (!bus.web0) begin
            if (bus.wmask0[0]) mem0[bus.addr0[9:0]] <= bus.din0[7:0];
         end else m0_d0 <= mem0[bus.addr0[9:0]];
      end
      if (!bus.csb1[0]) m0_d1 <= mem0[bus.addr1[9:0]];
      if (!bus.csb0[1]) begin
         if (!bus.web0) mem1[bus.addr0[7:0]] <= merge(mem1[bus.addr0[7:0]], bus.din0, bus.wmask0);
         else m1_d0 <= mem1[bus.addr0[7:0]];
      end
      if (!bus.csb1[1]) m1_d1 <= mem1[bus.addr1[7:0]];
      if (!bus.csb0[8]) begin
         if (!bus.web0) mem8[bus.addr0[7:0]] <= merge(mem8[bus.addr0[7:0]], bus.din0, bus.wmask0);
         else m8_d0 <= mem8[bus.addr0[7:0]];
      end
   end

   always_comb begin
      bus.data0    = '0;
      bus.data1    = '0;
      bus.data0[0] = {24'd0, m0_d0};
      bus.data1[0] = {24'd0, m0_d1};
      bus.data0[1] = m1_d0;
      bus.data1[1] = m1_d1;
      bus.data0[8] = m8_d0;
   end

   typedef struct {
      logic [111:0] pkt;
      logic [15:0]  c0;
      logic [15:0]  c1;
   } exp_t;

   exp_t         sb[$];
   logic [111:0] p_ref;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string name, input logic [111:0] got, input logic [111:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [15:0] ref_csb(input logic [3:0] sel, input logic pkt_csb,
                                           input logic g, input logic r);
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = !((k == int'(sel)) && !pkt_csb && !g && !r);
      return v;
   endfunction

   function automatic logic [111:0] mk(input logic [3:0] sel,
                                       input logic [15:0] a0, input logic [31:0] d0,
                                       input logic c0, input logic w0, input logic [3:0] m0,
                                       input logic [15:0] a1, input logic [31:0] d1,
                                       input logic c1, input logic w1, input logic [3:0] m1);
      return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
   endfunction

   // One clock: drive inputs, record what the outputs must show now, advance the model.
   task automatic cycle(input logic r, input logic lal, input logic [111:0] lad, input logic las,
                        input logic gi, input logic gs, input logic gsl, input logic gc);
      exp_t         e;
      logic [31:0]  d0, d1;
      logic [111:0] nx;
      reset = r; la_in_load = lal; la_data_in = lad; la_sram_load = las;
      gpio_in = gi; gpio_scan = gs; gpio_sram_load = gsl; global_csb = gc;
      e.pkt = p_ref;
      e.c0  = ref_csb(p_ref[111:108], p_ref[59], gc, r);
      e.c1  = ref_csb(p_ref[111:108], p_ref[5], gc, r);
      sb.push_back(e);
      d0 = bus.data0[p_ref[111:108]];
      d1 = bus.data1[p_ref[111:108]];
      if (r)              nx = '0;
      else if (lal)       nx = lad;
      else if (gs)        nx = {p_ref[110:0], gi};
      else if (las | gsl) nx = {p_ref[111:92], d0, p_ref[59:38], d1, p_ref[5:0]};
      else                nx = p_ref;
      @(posedge clk);
      #1;
      p_ref = nx;
   endtask

   task automatic scan_in(input logic [111:0] pkt);
      for (int i = 111; i >= 0; i--) cycle(1'b0, 1'b0, '0, 1'b0, pkt[i], 1'b1, 1'b0, 1'b1);
   endtask

   task automatic scan_out(output logic [111:0] got);
      for (int i = 111; i >= 0; i--) begin
         got[i] = gpio_out;
         cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
   endtask

   task automatic sram_op(input logic [111:0] pkt);
      scan_in(pkt);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("packet", la_data_out, e.pkt);
         check("gpio_out", {111'd0, gpio_out}, {111'd0, e.pkt[111]});
         check("bus_fields",
               {14'd0, bus.addr0, bus.din0, bus.web0, bus.wmask0,
                bus.addr1, bus.din1, bus.web1, bus.wmask1},
               {14'd0, e.pkt[107:92], e.pkt[91:60], e.pkt[58], e.pkt[57:54],
                e.pkt[53:38], e.pkt[37:6], e.pkt[4], e.pkt[3:0]});
         check("csb", {80'd0, bus.csb0, bus.csb1}, {80'd0, e.c0, e.c1});
      end
   end

   initial begin : stim
      logic [111:0] got, pat, keep;
      logic [127:0] rnd;
      reset = 1'b1; la_in_load = 1'b0; la_data_in = '0; la_sram_load = 1'b0;
      gpio_in = 1'b0; gpio_scan = 1'b0; gpio_sram_load = 1'b0; global_csb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      p_ref = '0;
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // dual-port write/read on sel 1 and sel 0
      for (int s = 1; s >= 0; s--) begin
         sram_op(mk(4'(s), 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0));
         sram_op(mk(4'(s), 16'd2, 32'd2, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0));
         sram_op(mk(4'(s), 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd2, 32'd0, 1'b0, 1'b1, 4'd0));
         scan_out(got);
         check(s == 1 ? "dp_sel1" : "dp_sel0", got,
               mk(4'(s), 16'd1, 32'd1, 1'b0, 1'b1, 4'd0, 16'd2, 32'd2, 1'b0, 1'b1, 4'd0));
      end

      // single-port macro on sel 8: port-1 data reads as zero
      sram_op(mk(4'd8, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0));
      sram_op(mk(4'd8, 16'd1, 32'd0, 1'b0, 1'b1, 4'd0, 16'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd0));
      scan_out(got);
      check("sp_sel8", got,
            mk(4'd8, 16'd1, 32'd1, 1'b0, 1'b1, 4'd0, 16'd1, 32'd0, 1'b0, 1'b1, 4'd0));

      // LA parallel load then capture from macro 1 (still presenting 1 and 2)
      rnd = {$urandom, $urandom, $urandom, $urandom};
      pat = rnd[111:0];
      pat[111:108] = 4'd1;
      cycle(1'b0, 1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("la_load", la_data_out, pat);
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      keep = {20'hFFFFF, 32'd0, 22'h3FFFFF, 32'd0, 6'h3F};
      check("la_cap_keep", la_data_out & keep, pat & keep);
      check("la_cap_data", {la_data_out[91:60], la_data_out[37:6]}, {48'd0, 32'd1, 32'd2});

      // chip-select decode with sel 5
      rnd = {$urandom, $urandom, $urandom, $urandom};
      pat = rnd[111:0];
      pat[111:108] = 4'd5;
      pat[59] = 1'b0;
      cycle(1'b0, 1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      pat[59] = 1'b1;
      pat[5]  = 1'b0;
      cycle(1'b0, 1'b1, pat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset after 50 shifts, with global_csb low while reset is held
      for (int i = 0; i < 50; i++)
         cycle(1'b0, 1'b0, '0, 1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("rst_pkt", la_data_out, 112'd0);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

      // parallel load wins over shift
      rnd = {$urandom, $urandom, $urandom, $urandom};
      pat = rnd[111:0];
      cycle(1'b0, 1'b1, pat, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("prio_load", la_data_out, pat);

      // random mix
      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0), rnd[111:0],
               1'($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0));
      end
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      #1;
      check("sb_drain", 112'(sb.size()), 112'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
